// File: rtl/tt_sweep_harness.sv
// tt_sweep_harness: exhaustive input sweep driver for small combinational netlists.
// Walks x_drv through every vector 0..2^N_IN-1, holds each for SETTLE_CYCLES,
// captures f_in, streams (vector, response) records over valid/ready and folds
// every response into a MISR signature.
// Optional build macro: TT_SWEEP_GOLDEN_CMP_EN adds a registered 'pass' output
// comparing the final signature against GOLDEN_SIG.
module tt_sweep_harness #(
    parameter int               N_IN          = 3,
    parameter int               N_OUT         = 10,
    parameter int               SETTLE_CYCLES = 1,
    parameter int               SIG_W         = 16,
    parameter logic [SIG_W-1:0] POLY          = 16'h1021,
    parameter logic [SIG_W-1:0] SEED          = 16'h0000
`ifdef TT_SWEEP_GOLDEN_CMP_EN
    ,
    parameter logic [SIG_W-1:0] GOLDEN_SIG    = '0
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  x_drv,
    input  logic [N_OUT-1:0] f_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N_IN-1:0]  rsp_vec,
    output logic [N_OUT-1:0] rsp_data,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
`ifdef TT_SWEEP_GOLDEN_CMP_EN
    ,
    output logic             pass
`endif
);

    // Counter only needs to hold SETTLE_CYCLES-1; keep at least one bit.
    localparam int              CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  X_LAST     = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    x_q, x_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vld_q, vld_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [N_OUT-1:0]   data_q, data_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [SIG_W-1:0]   f_ext;
    logic [SIG_W-1:0]   misr_next;

    // Zero-extend the response to the MISR width, bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < SIG_W; gi++) begin : g_fext
            if (gi < N_OUT) begin : g_bit
                assign f_ext[gi] = f_in[gi];
            end else begin : g_zero
                assign f_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? POLY : '0)
                     ^ f_ext;

`ifdef TT_SWEEP_GOLDEN_CMP_EN
    logic pass_q, pass_d;
`endif

    // Next-state and datapath: abort overrides everything, then per-state action.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        vec_d   = vec_q;
        data_d  = data_q;
        sig_d   = sig_q;
`ifdef TT_SWEEP_GOLDEN_CMP_EN
        pass_d  = pass_q;
`endif
        if (abort) begin
            // Signature deliberately survives an abort for post-mortem reads.
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            x_d     = '0;
`ifdef TT_SWEEP_GOLDEN_CMP_EN
            pass_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_d     = '0;
                        sig_d   = SEED;
                        cnt_d   = CNT_RELOAD;
                        state_d = ST_SETTLE;
`ifdef TT_SWEEP_GOLDEN_CMP_EN
                        pass_d  = 1'b0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        // Capture edge: the only place the MISR advances.
                        data_d  = f_in;
                        vec_d   = x_q;
                        vld_d   = 1'b1;
                        sig_d   = misr_next;
                        state_d = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (vld_q && rsp_ready) begin
                        vld_d = 1'b0;
                        if (x_q == X_LAST) begin
                            state_d = ST_DONE;
`ifdef TT_SWEEP_GOLDEN_CMP_EN
                            pass_d  = (sig_d == GOLDEN_SIG);
`endif
                        end else begin
                            x_d     = x_q + 1'b1;
                            cnt_d   = CNT_RELOAD;
                            state_d = ST_SETTLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            vec_q   <= '0;
            data_q  <= '0;
            sig_q   <= SEED;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            vec_q   <= vec_d;
            data_q  <= data_d;
            sig_q   <= sig_d;
        end
    end

`ifdef TT_SWEEP_GOLDEN_CMP_EN
    // Golden-signature verdict register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end

    assign pass = pass_q;
`endif

    assign x_drv     = x_q;
    assign rsp_valid = vld_q;
    assign rsp_vec   = vec_q;
    assign rsp_data  = data_q;
    assign signature = sig_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_EMIT);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_tt_sweep_harness.sv
// Bench for tt_sweep_harness: a lookup-table "netlist" drives f_in, a queue of
// expected records (vector, response, running signature) is built per sweep
// from plain arithmetic, and a negedge monitor checks every valid cycle.
module tb_tt_sweep_harness;

    localparam int          N_IN  = 3;
    localparam int          N_OUT = 10;
    localparam int          SIG_W = 16;
    localparam int          NVEC  = 8;
    localparam logic [15:0] POLY  = 16'h1021;
    localparam logic [15:0] SEED  = 16'h0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [N_IN-1:0]  x_drv;
    logic [N_OUT-1:0] f_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N_IN-1:0]  rsp_vec;
    logic [N_OUT-1:0] rsp_data;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;

    always #5 clk = ~clk;

    // Netlist under test modelled as a response table indexed by the vector.
    logic [N_OUT-1:0] lut [NVEC];
    always_comb f_in = lut[x_drv];

`ifdef TT_SWEEP_GOLDEN_CMP_EN
    logic             pass_a;
    logic             pass_b;
    logic [N_IN-1:0]  b_x_drv;
    logic             b_rsp_valid;
    logic [N_IN-1:0]  b_rsp_vec;
    logic [N_OUT-1:0] b_rsp_data;
    logic             b_busy;
    logic             b_done;
    logic [SIG_W-1:0] b_signature;
    logic [N_OUT-1:0] b_f_in;
    always_comb b_f_in = lut[b_x_drv];

    tt_sweep_harness #(.GOLDEN_SIG(16'h000F)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_drv(x_drv), .f_in(f_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_vec(rsp_vec), .rsp_data(rsp_data), .busy(busy), .done(done),
        .signature(signature), .pass(pass_a)
    );

    tt_sweep_harness #(.GOLDEN_SIG(16'h0010)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_drv(b_x_drv), .f_in(b_f_in), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_vec(b_rsp_vec), .rsp_data(b_rsp_data), .busy(b_busy), .done(b_done),
        .signature(b_signature), .pass(pass_b)
    );
`else
    tt_sweep_harness u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_drv(x_drv), .f_in(f_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_vec(rsp_vec), .rsp_data(rsp_data), .busy(busy), .done(done),
        .signature(signature)
    );
`endif

    typedef struct {
        logic [31:0] vec;
        logic [31:0] data;
        logic [31:0] sig;
    } rec_t;

    rec_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: stall 5 cycles on vector 3
    int          stall_cnt = 0;
    int          stall_seen = 0;
    int          rec_cnt = 0;
    longint      last_hs = -1;
    longint      t_start = 0;
    logic [15:0] exp_sig;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference MISR step: shift, conditional polynomial, fold in response.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [N_OUT-1:0] d);
        logic [15:0] r;
        r = (s << 1) ^ {6'b0, d};
        if (s[15]) r = r ^ POLY;
        return r;
    endfunction

    // Consumer behaviour, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: rsp_ready = ($urandom_range(0, 1) == 1);
            2: begin
                if (rsp_valid && rsp_vec == 3'd3 && stall_cnt < 5) begin
                    rsp_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    rsp_ready = 1'b1;
                end
            end
            default: rsp_ready = 1'b1;
        endcase
    end

    // Compare process: every valid cycle must show the head expected record.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_record: got vec %0h, no record expected at %0t", rsp_vec, $time);
            end else begin
                check("rsp_vec", 32'(rsp_vec), exp_q[0].vec);
                check("rsp_data", 32'(rsp_data), exp_q[0].data);
                check("signature_emit", 32'(signature), exp_q[0].sig);
                check("x_drv_hold", 32'(x_drv), exp_q[0].vec);
                if (!rsp_ready && exp_q[0].vec == 3) stall_seen++;
                if (rsp_ready) begin
                    if (ready_mode == 0 && last_hs >= 0)
                        check("rec_spacing", 32'($time - last_hs), 32'd20);
                    last_hs = $time;
                    void'(exp_q.pop_front());
                    rec_cnt++;
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_x_drv"}, 32'(x_drv), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_vec"}, 32'(rsp_vec), 0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_signature"}, 32'(signature), 32'(SEED));
    endtask

    // fmode: 0 identity, 1 all-zero, 2 random table.
    task automatic begin_sweep(input int rmode, input int fmode);
        logic [15:0] s;
        ready_mode = rmode;
        stall_cnt  = 0;
        stall_seen = 0;
        rec_cnt    = 0;
        last_hs    = -1;
        for (int v = 0; v < NVEC; v++) begin
            case (fmode)
                0:       lut[v] = N_OUT'(v);
                1:       lut[v] = '0;
                default: lut[v] = N_OUT'($urandom_range(0, 1023));
            endcase
        end
        exp_q.delete();
        s = SEED;
        for (int v = 0; v < NVEC; v++) begin
            rec_t r;
            s = misr_step(s, lut[v]);
            r.vec  = v;
            r.data = 32'(lut[v]);
            r.sig  = 32'(s);
            exp_q.push_back(r);
        end
        exp_sig = s;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        t_start = $time;
        #1 start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_done", 32'(done), 0);
        check("start_x_drv", 32'(x_drv), 0);
        check("start_signature", 32'(signature), 32'(SEED));
`ifdef TT_SWEEP_GOLDEN_CMP_EN
        check("start_pass", 32'(pass_a), 0);
`endif
    endtask

    task automatic finish_sweep(input bit chk_time, input logic [16:0] lit);
        bit seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_reached", 32'(seen), 1);
        if (seen) begin
            if (chk_time) check("sweep_cycles", 32'($time - t_start), 32'(16 * 10 + 5));
            check("final_signature", 32'(signature), 32'(exp_sig));
            if (lit[16]) check("signature_literal", 32'(signature), 32'(lit[15:0]));
            check("records_left", 32'(exp_q.size()), 0);
            check("records_seen", 32'(rec_cnt), NVEC);
            check("done_busy", 32'(busy), 0);
            check("done_valid", 32'(rsp_valid), 0);
            check("done_x_drv", 32'(x_drv), NVEC - 1);
`ifdef TT_SWEEP_GOLDEN_CMP_EN
            check("pass_golden_000f", 32'(pass_a), 32'(exp_sig == 16'h000F));
            check("pass_golden_0010", 32'(pass_b), 32'(exp_sig == 16'h0010));
`endif
        end
    endtask

    task automatic wait_negedge_until_vec(input int v, input bit in_emit, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_emit ? (rsp_valid && rsp_vec == N_IN'(v))
                        : (busy && !rsp_valid && x_drv == N_IN'(v))) begin
                ok = 1;
                break;
            end
        end
        check("wait_vec_reached", 32'(ok), 1);
    endtask

    initial begin
        bit ok;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        rsp_ready = 1'b1;
        for (int v = 0; v < NVEC; v++) lut[v] = N_OUT'(v);
        #1 check_reset_values("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Identity netlist, always ready: literal signature 000F, 16-cycle sweep.
        begin_sweep(0, 0);
        finish_sweep(1, 17'h1000F);

        // All-zero responses.
        begin_sweep(0, 1);
        finish_sweep(1, 17'h10000);

        // Back-pressure on vector 3 for five cycles.
        begin_sweep(2, 0);
        finish_sweep(0, 17'h1000F);
        check("stall_cycles", 32'(stall_seen), 5);

        // Abort while settling vector 5.
        begin_sweep(0, 0);
        wait_negedge_until_vec(5, 0, ok);
        if (ok) begin
            #1 abort = 1'b1;
            start = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            start = 1'b0;
            check("abort_busy", 32'(busy), 0);
            check("abort_valid", 32'(rsp_valid), 0);
            check("abort_x_drv", 32'(x_drv), 0);
            check("abort_done", 32'(done), 0);
            check("abort_signature_kept", 32'(signature), 32'h0002);
            exp_q.delete();
            @(posedge clk);
            #1 check("abort_stays_idle", 32'(busy), 0);
        end
        exp_q.delete();
        begin_sweep(0, 0);
        finish_sweep(1, 17'h1000F);

        // Asynchronous reset during EMIT of vector 3.
        begin_sweep(0, 0);
        wait_negedge_until_vec(3, 1, ok);
        if (ok) begin
            #2 rst_n = 1'b0;
            #1 check_reset_values("midrst");
            exp_q.delete();
            @(negedge clk) rst_n = 1'b1;
            @(posedge clk);
            #1 check("midrst_idle", 32'(busy), 0);
        end
        exp_q.delete();
        rst_n = 1'b1;

        // Start pulsed while busy on vector 2 must be ignored.
        begin_sweep(0, 0);
        wait_negedge_until_vec(2, 0, ok);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_sweep(1, 17'h1000F);

        // Random netlists with random back-pressure, restarting from DONE.
        for (int k = 0; k < 4; k++) begin
            begin_sweep(1, 2);
            finish_sweep(0, 17'h00000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_sweep_harness.md
Name: tt_sweep_harness

Overview:
- Sequential stimulus/response harness for the small combinational benchmark netlists in the dataset flow.
- Drives every input vector 0..2^N_IN-1 onto a benchmark's inputs and waits a fixed settle time after each one.
- Captures the benchmark's outputs, streams each (vector, response) pair over a valid/ready interface, and compacts all responses into a MISR signature.
- Sits between the generated netlist under test and the dataset/equivalence checker; it is the driving-and-reading end of the netlist's x*/f* interface.

Parameters:
N_IN, 3, number of DUT inputs driven (1..16)
N_OUT, 10, number of DUT outputs read (1..SIG_W)
SETTLE_CYCLES, 1, cycles each vector is held before capture (>=1)
SIG_W, 16, MISR width
POLY, 16'h1021, MISR feedback polynomial
SEED, 16'h0000, MISR initial value

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sweep; sampled only in IDLE or DONE
abort  in  1  cancel the sweep and return to IDLE
x_drv  out  N_IN  vector currently driven to DUT inputs
f_in  in  N_OUT  DUT outputs
rsp_valid  out  1  response record valid
rsp_ready  in  1  consumer accepts the record
rsp_vec  out  N_IN  vector of the record
rsp_data  out  N_OUT  captured DUT response
busy  out  1  high in SETTLE or EMIT
done  out  1  high in DONE
signature  out  SIG_W  MISR state

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; x_drv=0, rsp_valid=0, rsp_vec=0, rsp_data=0, busy=0, done=0, signature=SEED, settle counter=0.
- States: IDLE, SETTLE, EMIT, DONE.
- IDLE: if start=1, set x_drv=0, signature=SEED, counter=SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE: x_drv is held stable.
  - Counter !=0: decrement it.
  - Counter ==0: register rsp_data<=f_in and rsp_vec<=x_drv, set rsp_valid<=1, update the MISR, go to EMIT.
- MISR update: sig' = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(f_in). The update happens exactly once per vector, on the capture edge.
- EMIT: rsp_valid=1; rsp_vec, rsp_data and x_drv stay stable until rsp_valid&rsp_ready at a clock edge. On that handshake:
  - rsp_valid<=0.
  - If x_drv==2^N_IN-1, go to DONE; x_drv is held.
  - Otherwise x_drv<=x_drv+1, counter reloads to SETTLE_CYCLES-1, go to SETTLE.
- DONE: done=1; signature and rsp_vec/rsp_data are held. start=1 restarts exactly as from IDLE (same cycle transition; done falls on the next edge).
- abort has the highest priority, in any state: next edge gives IDLE, rsp_valid=0, x_drv=0. signature keeps its last value (not reset).
- start is ignored while busy. start and abort in the same cycle: abort wins.
- rsp_valid never drops without a handshake, except on abort or reset.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronous); no record is emitted.
- Throughput with rsp_ready tied high: one vector per SETTLE_CYCLES+1 cycles. A full sweep takes 2^N_IN*(SETTLE_CYCLES+1) cycles from the start-sampling edge to done=1.
- x_drv increment never wraps: the terminal vector always leads to DONE.

Optional Feature:
Macro TT_SWEEP_GOLDEN_CMP_EN.
- Defined:
  - Adds parameter GOLDEN_SIG (SIG_W, default 0).
  - Adds output pass (1 bit). pass is registered; it is set on entry to DONE to (signature_next==GOLDEN_SIG).
  - pass is cleared on start, abort and reset.
- Not defined: no pass port and no comparator; behaviour is otherwise identical.

Test Plan:
- Defaults; bench model f_in = zero_ext(x_drv) (identity DUT); rsp_ready=1; pulse start -> records rsp_vec 0..7 with rsp_data = vector, one every 2 cycles; done=1 16 cycles after the start edge; signature=16'h000F.
- f_in tied to 0, SEED=0 -> 8 records with rsp_data=0, signature=16'h0000, done=1.
- rsp_ready held low for 5 cycles while rsp_vec=3 -> rsp_valid stays 1; rsp_vec=3, rsp_data and x_drv=3 stable throughout; no MISR update; sweep resumes after ready rises and still ends with signature 16'h000F.
- abort asserted while x_drv=5, in state SETTLE -> next edge: busy=0, rsp_valid=0, x_drv=0. A following start yields the full 8-record sweep again.
- rst_n pulled low mid-EMIT, then released -> outputs immediately at reset values, state IDLE, signature=SEED. start while busy (vector 2) is ignored; start in DONE restarts from vector 0.
- With TT_SWEEP_GOLDEN_CMP_EN and GOLDEN_SIG=16'h000F on the identity DUT -> pass=1 in DONE. With GOLDEN_SIG=16'h0010 -> pass=0.
